// File: rtl/ov7670_config.sv
`timescale 1ns/1ps
// ov7670_config
//   Walks an internal 64-entry register table and feeds each entry to an
//   external SCCB write engine to bring up an OV7670 camera (RGB565, VGA).
//   Entry format is {addr[15:8], data[7:0]}:
//     FF/FF     end of table
//     F0/nn     wait nn milliseconds
//     other     one register write of data to addr
//
//   Optional feature: define OV7670_CFG_TIMEOUT_EN to abort a write that
//   gets no sccb_done within TIMEOUT_CYCLES; the run then ends in ERR with
//   cfg_error=1. Without the macro a write waits indefinitely and cfg_error
//   is tied 0.
//
//   Ports
//     clk, reset   rising-edge clock, synchronous active-high reset
//     cfg_start    single-cycle request to run the table from entry 0
//     sccb_start   write request to the engine (held until engine busy)
//     sccb_addr    register address of the current write
//     sccb_data    register data of the current write
//     sccb_busy    engine busy level
//     sccb_done    engine single-cycle completion pulse
//     cfg_busy     table run in progress
//     cfg_done     table completed (held until next cfg_start or reset)
//     cfg_error    run aborted on timeout
//     cfg_index    index of the current table entry
//     dbg_state    current FSM state encoding, for observation only
//
//   Handshake: sccb_start rises the cycle after FETCH and stays high until
//   sccb_busy=1 or sccb_done=1 is sampled; sccb_addr/sccb_data are stable
//   from FETCH until sccb_done completes the write.
module ov7670_config #(
    parameter int CLK_FREQ_HZ    = 25000000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_start,
    output logic       sccb_start,
    output logic [7:0] sccb_addr,
    output logic [7:0] sccb_data,
    input  logic       sccb_busy,
    input  logic       sccb_done,
    output logic       cfg_busy,
    output logic       cfg_done,
    output logic       cfg_error,
    output logic [5:0] cfg_index,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        REQ   = 3'd2,
        WAIT  = 3'd3,
        DELAY = 3'd4,
        NEXT  = 3'd5,
        DONE  = 3'd6,
        ERR   = 3'd7
    } state_t;

    localparam logic [31:0] MS_CYCLES = 32'(CLK_FREQ_HZ / 1000);

    state_t      state_q;
    logic        start_q;
    logic [7:0]  addr_q;
    logic [7:0]  data_q;
    logic        busy_q;
    logic        done_q;
    logic [5:0]  index_q;
    logic [31:0] delay_q;

    logic [15:0] entry_d;
    logic [31:0] delay_load_d;

    // Register table: bring-up sequence followed by the RGB565 VGA set.
    function automatic logic [15:0] rom_entry(input logic [5:0] idx);
        case (idx)
            6'd0:  rom_entry = 16'h1280;  // COM7: register reset
            6'd1:  rom_entry = 16'hF00A;  // let the sensor settle 10 ms
            6'd2:  rom_entry = 16'h1204;  // COM7: RGB output
            6'd3:  rom_entry = 16'h40D0;  // COM15: RGB565, full range
            6'd4:  rom_entry = 16'h1101;  // CLKRC: prescale by 2
            6'd5:  rom_entry = 16'h0C00;
            6'd6:  rom_entry = 16'h3E00;
            6'd7:  rom_entry = 16'h0400;
            6'd8:  rom_entry = 16'h8C00;
            6'd9:  rom_entry = 16'h3A04;
            6'd10: rom_entry = 16'h1438;
            6'd11: rom_entry = 16'h4FB3;
            6'd12: rom_entry = 16'h50B3;
            6'd13: rom_entry = 16'h5100;
            6'd14: rom_entry = 16'h523D;
            6'd15: rom_entry = 16'h53A7;
            6'd16: rom_entry = 16'h54E4;
            6'd17: rom_entry = 16'h589E;
            6'd18: rom_entry = 16'h3DC0;
            6'd19: rom_entry = 16'h1714;
            6'd20: rom_entry = 16'h1802;
            6'd21: rom_entry = 16'h3280;
            6'd22: rom_entry = 16'h1903;
            6'd23: rom_entry = 16'h1A7B;
            6'd24: rom_entry = 16'h030A;
            6'd25: rom_entry = 16'h0F41;
            6'd26: rom_entry = 16'h1E00;
            6'd27: rom_entry = 16'h330B;
            6'd28: rom_entry = 16'h3C78;
            6'd29: rom_entry = 16'h6900;
            6'd30: rom_entry = 16'h7400;
            6'd31: rom_entry = 16'hB084;
            6'd32: rom_entry = 16'hB10C;
            6'd33: rom_entry = 16'hB20E;
            6'd34: rom_entry = 16'hB380;
            default: rom_entry = 16'hFFFF;  // end marker and unused entries
        endcase
    endfunction

    always_comb begin
        entry_d      = rom_entry(index_q);
        delay_load_d = {24'd0, entry_d[7:0]} * MS_CYCLES;
    end

`ifdef OV7670_CFG_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_q;
    logic            error_q;
    assign cfg_error = error_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign cfg_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            addr_q  <= 8'd0;
            data_q  <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            index_q <= 6'd0;
            delay_q <= 32'd0;
`ifdef OV7670_CFG_TIMEOUT_EN
            to_q    <= '0;
            error_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (cfg_start) begin
                        index_q <= 6'd0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
`ifdef OV7670_CFG_TIMEOUT_EN
                        error_q <= 1'b0;
`endif
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    addr_q <= entry_d[15:8];
                    data_q <= entry_d[7:0];
                    if (entry_d == 16'hFFFF) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (entry_d[15:8] == 8'hF0) begin
                        delay_q <= delay_load_d;
                        state_q <= DELAY;
                    end else begin
                        start_q <= 1'b1;
`ifdef OV7670_CFG_TIMEOUT_EN
                        to_q    <= '0;
`endif
                        state_q <= REQ;
                    end
                end
                REQ, WAIT: begin
                    // Completion wins over everything, then timeout, then
                    // the busy acknowledge that releases sccb_start.
                    if (sccb_done) begin
                        start_q <= 1'b0;
                        state_q <= NEXT;
`ifdef OV7670_CFG_TIMEOUT_EN
                    end else if (to_q == TO_LAST) begin
                        start_q <= 1'b0;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                        state_q <= ERR;
`endif
                    end else begin
`ifdef OV7670_CFG_TIMEOUT_EN
                        to_q <= to_q + TO_W'(1);
`endif
                        if (state_q == REQ && sccb_busy) begin
                            start_q <= 1'b0;
                            state_q <= WAIT;
                        end
                    end
                end
                DELAY: begin
                    // A zero-length delay still spends one cycle here.
                    if (delay_q <= 32'd1) begin
                        state_q <= NEXT;
                    end else begin
                        delay_q <= delay_q - 32'd1;
                    end
                end
                NEXT: begin
                    if (index_q == 6'd63) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        index_q <= index_q + 6'd1;
                        state_q <= FETCH;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sccb_start = start_q;
    assign sccb_addr  = addr_q;
    assign sccb_data  = data_q;
    assign cfg_busy   = busy_q;
    assign cfg_done   = done_q;
    assign cfg_index  = index_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_ov7670_config.sv
`timescale 1ns/1ps
module tb_ov7670_config;

  localparam int CLK_FREQ_HZ    = 1000000;
  localparam int TIMEOUT_CYCLES = 100;
  localparam int END_IDX        = 35;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_REQ   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DELAY = 3'd4;
  localparam logic [2:0] S_NEXT  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERR   = 3'd7;

  // Expected configuration table, entry 0 up to and including the end marker.
  localparam logic [15:0] TABLE [0:END_IDX] = '{
    16'h1280, 16'hF00A, 16'h1204, 16'h40D0, 16'h1101, 16'h0C00, 16'h3E00,
    16'h0400, 16'h8C00, 16'h3A04, 16'h1438, 16'h4FB3, 16'h50B3, 16'h5100,
    16'h523D, 16'h53A7, 16'h54E4, 16'h589E, 16'h3DC0, 16'h1714, 16'h1802,
    16'h3280, 16'h1903, 16'h1A7B, 16'h030A, 16'h0F41, 16'h1E00, 16'h330B,
    16'h3C78, 16'h6900, 16'h7400, 16'hB084, 16'hB10C, 16'hB20E, 16'hB380,
    16'hFFFF
  };

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_start;
  logic       sccb_start;
  logic [7:0] sccb_addr;
  logic [7:0] sccb_data;
  logic       sccb_busy;
  logic       sccb_done;
  logic       cfg_busy;
  logic       cfg_done;
  logic       cfg_error;
  logic [5:0] cfg_index;
  logic [2:0] dbg_state;

  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int n_writes = 0;
  logic eng_hang = 1'b0;

  ov7670_config #(
    .CLK_FREQ_HZ   (CLK_FREQ_HZ),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_start (cfg_start),
    .sccb_start(sccb_start),
    .sccb_addr (sccb_addr),
    .sccb_data (sccb_data),
    .sccb_busy (sccb_busy),
    .sccb_done (sccb_done),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done),
    .cfg_error (cfg_error),
    .cfg_index (cfg_index),
    .dbg_state (dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 5 ms");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic pulse_start();
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic push_table();
    logic [15:0] e;
    for (int i = 0; i <= END_IDX; i++) begin
      e = TABLE[i];
      if (e != 16'hFFFF && e[15:8] != 8'hF0) exp_q.push_back(e);
    end
  endtask

  // SCCB engine model: busy 3 cycles after start is seen, done 40 cycles
  // after busy. Each completed write is scored against exp_q.
  initial begin : engine
    int st;
    int cnt;
    int start_hi;
    logic [15:0] cap;
    st = 0; cnt = 0; start_hi = 0; cap = 16'h0;
    sccb_busy = 1'b0;
    sccb_done = 1'b0;
    forever begin
      @(negedge clk);
      sccb_done = 1'b0;
      if (reset) begin
        st = 0;
        sccb_busy = 1'b0;
      end else begin
        case (st)
          0: if (sccb_start) begin
               st = 1; cnt = 0; start_hi = 1;
               cap = {sccb_addr, sccb_data};
             end
          1: begin
               cnt++;
               if (sccb_start) start_hi++;
               if (cnt == 3) begin
                 sccb_busy = 1'b1;
                 st = 2; cnt = 0;
               end
             end
          default: begin
               if (sccb_start) start_hi++;
               cnt++;
               if (cnt == 40 && !eng_hang) begin
                 sccb_done = 1'b1;
                 sccb_busy = 1'b0;
                 st = 0;
                 n_writes++;
                 check("start_len", 32'(start_hi), 32'd4);
                 check("addr_data_stable", {16'h0, sccb_addr, sccb_data}, {16'h0, cap});
                 check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
                 if (exp_q.size() != 0) check("write", {16'h0, cap}, {16'h0, exp_q.pop_front()});
               end
             end
        endcase
      end
    end
  end

  // Directed sequence
  initial begin : stim
    int guard;
    int dcnt;
    int seen;
    reset = 1'b1;
    cfg_start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sccb_start", 32'(sccb_start), 32'd0);
    check("rst_addr", 32'(sccb_addr), 32'd0);
    check("rst_data", 32'(sccb_data), 32'd0);
    check("rst_busy", 32'(cfg_busy), 32'd0);
    check("rst_done", 32'(cfg_done), 32'd0);
    check("rst_error", 32'(cfg_error), 32'd0);
    check("rst_index", 32'(cfg_index), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    reset = 1'b0;
    @(negedge clk);
    check("idle_hold", 32'(dbg_state), 32'(S_IDLE));

    // Run 1: full table
    push_table();
    pulse_start();
    check("run1_fetch", 32'(dbg_state), 32'(S_FETCH));
    check("run1_busy", 32'(cfg_busy), 32'd1);
    check("run1_index", 32'(cfg_index), 32'd0);
    @(negedge clk);
    check("run1_req", 32'(dbg_state), 32'(S_REQ));
    check("run1_start", 32'(sccb_start), 32'd1);
    check("run1_first_word", {16'h0, sccb_addr, sccb_data}, 32'h1280);

    guard = 0;
    while (dbg_state != S_DELAY && guard < 500) begin @(negedge clk); guard++; end
    check("reach_delay", 32'(dbg_state), 32'(S_DELAY));
    check("writes_before_delay", 32'(n_writes), 32'd1);
    dcnt = 0;
    while (dbg_state == S_DELAY && dcnt < 20000) begin dcnt++; @(negedge clk); end
    check("delay_cycles", 32'(dcnt), 32'd10000);
    check("after_delay", 32'(dbg_state), 32'(S_NEXT));
    @(negedge clk);
    check("entry2_fetch", 32'(dbg_state), 32'(S_FETCH));
    check("entry2_index", 32'(cfg_index), 32'd2);
    @(negedge clk);
    check("entry2_word", {16'h0, sccb_addr, sccb_data}, 32'h1204);

    // cfg_start during WAIT of entry 3 must be ignored
    guard = 0;
    while (!(cfg_index == 6'd3 && dbg_state == S_WAIT) && guard < 500) begin @(negedge clk); guard++; end
    check("reach_wait3", {29'h0, dbg_state}, 32'(S_WAIT));
    pulse_start();
    check("ignored_start_index", 32'(cfg_index), 32'd3);
    check("ignored_start_busy", 32'(cfg_busy), 32'd1);
    guard = 0;
    while (cfg_index == 6'd3 && guard < 500) begin @(negedge clk); guard++; end
    check("index_3_to_4", 32'(cfg_index), 32'd4);

    guard = 0;
    while (!cfg_done && guard < 5000) begin @(negedge clk); guard++; end
    check("run1_done", 32'(cfg_done), 32'd1);
    check("run1_busy_low", 32'(cfg_busy), 32'd0);
    check("run1_end_index", 32'(cfg_index), 32'(END_IDX));
    check("run1_state", 32'(dbg_state), 32'(S_DONE));
    check("run1_sb_empty", 32'(exp_q.size()), 32'd0);
    check("run1_writes", 32'(n_writes), 32'd34);
    seen = 0;
    repeat (50) begin @(negedge clk); if (sccb_start) seen++; end
    check("no_start_after_done", 32'(seen), 32'd0);
    check("done_held", 32'(cfg_done), 32'd1);

    // Run 2: restart from done, then reset during WAIT of entry 0
    exp_q.push_back(16'h1280);
    pulse_start();
    check("rerun_done_clr", 32'(cfg_done), 32'd0);
    check("rerun_busy", 32'(cfg_busy), 32'd1);
    check("rerun_index", 32'(cfg_index), 32'd0);
    @(negedge clk);
    check("rerun_word", {16'h0, sccb_addr, sccb_data}, 32'h1280);
    guard = 0;
    while (dbg_state != S_WAIT && guard < 100) begin @(negedge clk); guard++; end
    check("rerun_wait", 32'(dbg_state), 32'(S_WAIT));
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_start", 32'(sccb_start), 32'd0);
    check("mid_rst_addr", 32'(sccb_addr), 32'd0);
    check("mid_rst_data", 32'(sccb_data), 32'd0);
    check("mid_rst_busy", 32'(cfg_busy), 32'd0);
    check("mid_rst_done", 32'(cfg_done), 32'd0);
    check("mid_rst_error", 32'(cfg_error), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(S_IDLE));
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    repeat (5) @(negedge clk);
    check("no_auto_restart", 32'(dbg_state), 32'(S_IDLE));

    // Run 3: full table again after reset
    push_table();
    pulse_start();
    @(negedge clk);
    check("run3_first_word", {16'h0, sccb_addr, sccb_data}, 32'h1280);
    guard = 0;
    while (!cfg_done && guard < 15000) begin @(negedge clk); guard++; end
    check("run3_done", 32'(cfg_done), 32'd1);
    check("run3_sb_empty", 32'(exp_q.size()), 32'd0);
    check("run3_writes", 32'(n_writes), 32'd68);

    // Engine that never completes
    eng_hang = 1'b1;
    pulse_start();
    guard = 0;
    while (dbg_state != S_REQ && guard < 10) begin @(negedge clk); guard++; end
    check("hang_req", 32'(dbg_state), 32'(S_REQ));
`ifdef OV7670_CFG_TIMEOUT_EN
    repeat (TIMEOUT_CYCLES - 1) @(negedge clk);
    check("timeout_not_yet", 32'(cfg_error), 32'd0);
    @(negedge clk);
    check("timeout_error", 32'(cfg_error), 32'd1);
    check("timeout_busy", 32'(cfg_busy), 32'd0);
    check("timeout_start", 32'(sccb_start), 32'd0);
    check("timeout_state", 32'(dbg_state), 32'(S_ERR));
`else
    repeat (3 * TIMEOUT_CYCLES) @(negedge clk);
    check("hang_busy", 32'(cfg_busy), 32'd1);
    check("hang_error", 32'(cfg_error), 32'd0);
    check("hang_state", 32'(dbg_state), 32'(S_WAIT));
`endif
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    eng_hang = 1'b0;
    @(negedge clk);
    check("final_idle", 32'(dbg_state), 32'(S_IDLE));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
